channel_accumulator: RTL and testbench

Downstream consumer of the channel selector in the parallel convolution datapath. It sequences the selector's channel index through every input channel. On each step it adds the selected per-PE partial results into one accumulator per PE. After the last channel it presents the summed multi-channel convolution outputs with a valid/ready handshake. The output-channel result for all PE_NUM processing elements is therefore produced from the IN_CH per-channel partial sums.

---
 rtl/channel_accumulator_if.sv | 39 +++
 rtl/channel_accumulator.sv | 146 ++++++++++++++
 tb/tb_channel_accumulator.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/channel_accumulator_if.sv
// ----------------------------------------------------------------------------
// channel_accumulator_if
// Bundles the selector-facing and result-facing signals of the channel
// accumulator.
//   i_start    : one-cycle request, upstream per-channel data valid and stable
//   o_ch_sel   : channel index driven to the selector
//   i_sel_data : selector output, lane p at [p*WIDTH +: WIDTH]
//   o_busy     : high while channels are being accumulated
//   o_valid    : o_data holds a completed sum
//   i_ready    : downstream accepts o_data
//   o_data     : summed lanes, lane p at [p*ACC_WIDTH +: ACC_WIDTH]
// master = upstream/downstream environment, slave = the accumulator.
// ----------------------------------------------------------------------------
interface channel_accumulator_if #(
   parameter int WIDTH     = 30,
   parameter int IN_CH     = 3,
   parameter int PE_NUM    = 2,
   parameter int ACC_WIDTH = 32
);
   localparam int SEL_W = $clog2(IN_CH) + 1;

   logic                        i_start;
   logic [SEL_W-1:0]            o_ch_sel;
   logic [WIDTH*PE_NUM-1:0]     i_sel_data;
   logic                        o_busy;
   logic                        o_valid;
   logic                        i_ready;
   logic [ACC_WIDTH*PE_NUM-1:0] o_data;

   modport master (
      output i_start, i_sel_data, i_ready,
      input  o_ch_sel, o_busy, o_valid, o_data
   );

   modport slave (
      input  i_start, i_sel_data, i_ready,
      output o_ch_sel, o_busy, o_valid, o_data
   );
endinterface

// File: rtl/channel_accumulator.sv
// ----------------------------------------------------------------------------
// channel_accumulator
// Walks the channel selector through all IN_CH input channels, summing the
// selected per-PE partial results into one signed accumulator per PE, then
// presents the PE_NUM sums with a valid/ready handshake.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : channel_accumulator_if.slave (start, selector index/data,
//             busy, valid/ready result)
// ----------------------------------------------------------------------------
module channel_accumulator #(
   parameter int WIDTH     = 30,
   parameter int IN_CH     = 3,
   parameter int PE_NUM    = 2,
   parameter int ACC_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   channel_accumulator_if.slave  bus
);
   localparam int               SEL_W   = $clog2(IN_CH) + 1;
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(IN_CH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                             state_r;
   state_t                             next_state_s;
   logic [SEL_W-1:0]                   ch_cnt_r;
   logic [PE_NUM-1:0][ACC_WIDTH-1:0]   acc_r;
   logic [PE_NUM-1:0][ACC_WIDTH-1:0]   acc_next_s;
   logic                               busy_s;
   logic                               valid_s;

   // Signed widening of one PE lane to accumulator width (truncates if narrower)
   function automatic logic [ACC_WIDTH-1:0] sign_extend(input logic [WIDTH-1:0] v);
      return ACC_WIDTH'($signed(v));
   endfunction

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.i_start) begin
               next_state_s = ST_ACCUM;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            // i_start is deliberately ignored while accumulating
            if (ch_cnt_r == LAST_CH) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_ACCUM;
            end
         end
         ST_DONE: begin
            if (bus.i_ready) begin
               // a start in the accepting cycle chains the next sum directly
               if (bus.i_start) begin
                  next_state_s = ST_ACCUM;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end else begin
               next_state_s = ST_DONE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Output decode, taken straight from the state register
   always_comb begin
      busy_s  = 1'b0;
      valid_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy_s  = 1'b0;
            valid_s = 1'b0;
         end
         ST_ACCUM: begin
            busy_s  = 1'b1;
            valid_s = 1'b0;
         end
         ST_DONE: begin
            busy_s  = 1'b0;
            valid_s = 1'b1;
         end
         default: begin
            busy_s  = 1'b0;
            valid_s = 1'b0;
         end
      endcase
   end

   // Per-lane adder; channel 0 restarts the sum so no earlier result leaks in
   always_comb begin
      acc_next_s = '0;
      for (int p = 0; p < PE_NUM; p++) begin
         if (ch_cnt_r == '0) begin
            acc_next_s[p] = sign_extend(bus.i_sel_data[p*WIDTH +: WIDTH]);
         end else begin
            acc_next_s[p] = acc_r[p] + sign_extend(bus.i_sel_data[p*WIDTH +: WIDTH]);
         end
      end
   end

   // Accumulators and channel counter; both only move during ACCUM
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_r    <= '0;
         ch_cnt_r <= '0;
      end else if (state_r == ST_ACCUM) begin
         acc_r <= acc_next_s;
         if (ch_cnt_r == LAST_CH) begin
            ch_cnt_r <= '0;
         end else begin
            ch_cnt_r <= ch_cnt_r + SEL_W'(1);
         end
      end
   end

   assign bus.o_ch_sel = ch_cnt_r;
   assign bus.o_data   = acc_r;
   assign bus.o_busy   = busy_s;
   assign bus.o_valid  = valid_s;

endmodule

// File: tb/tb_channel_accumulator.sv
// ----------------------------------------------------------------------------
// tb_channel_accumulator
// Self-checking bench: a selector model feeds per-channel data, expected sums
// are queued at stimulus time and compared when the accumulator presents them.
// ----------------------------------------------------------------------------
module tb_channel_accumulator;
   localparam int WIDTH     = 30;
   localparam int IN_CH     = 3;
   localparam int PE_NUM    = 2;
   localparam int ACC_WIDTH = 32;
   localparam int DW        = ACC_WIDTH * PE_NUM;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   channel_accumulator_if #(
      .WIDTH(WIDTH), .IN_CH(IN_CH), .PE_NUM(PE_NUM), .ACC_WIDTH(ACC_WIDTH)
   ) bus ();

   channel_accumulator #(
      .WIDTH(WIDTH), .IN_CH(IN_CH), .PE_NUM(PE_NUM), .ACC_WIDTH(ACC_WIDTH)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   logic [WIDTH*PE_NUM-1:0] ch_data [IN_CH];
   logic [DW-1:0]           exp_q [$];
   int                      total = 0;
   int                      bad   = 0;
   int                      sel_idx;

   // Selector model: returns the addressed channel's lanes
   always_comb begin
      sel_idx = int'(bus.o_ch_sel);
      if (sel_idx < IN_CH) begin
         bus.i_sel_data = ch_data[sel_idx];
      end else begin
         bus.i_sel_data = '0;
      end
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_chan(input int c, input int l0, input int l1);
      ch_data[c] = {WIDTH'(l1), WIDTH'(l0)};
   endtask

   // Reference sum of the current channel data set
   function automatic logic [DW-1:0] model_sum();
      logic [DW-1:0] r;
      longint        s;
      r = '0;
      for (int p = 0; p < PE_NUM; p++) begin
         s = 0;
         for (int c = 0; c < IN_CH; c++) begin
            s += longint'($signed(ch_data[c][p*WIDTH +: WIDTH]));
         end
         r[p*ACC_WIDTH +: ACC_WIDTH] = s[ACC_WIDTH-1:0];
      end
      return r;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"},  bus.o_busy,   '0);
      check_eq({tag, "_valid"}, bus.o_valid,  '0);
      check_eq({tag, "_sel"},   bus.o_ch_sel, '0);
      check_eq({tag, "_data"},  bus.o_data,   '0);
   endtask

   // Called at the negedge where i_start was just raised
   task automatic do_accum(input bit poke_start);
      @(negedge clk);
      bus.i_start = 1'b0;
      for (int k = 0; k < IN_CH; k++) begin
         check_eq("ch_sel",   bus.o_ch_sel, DW'(k));
         check_eq("busy",     bus.o_busy,   '1 & DW'(1));
         check_eq("no_valid", bus.o_valid,  '0);
         if (poke_start && k == 0) bus.i_start = 1'b1;
         if (poke_start && k == 1) bus.i_start = 1'b0;
         if (k < IN_CH - 1) @(negedge clk);
      end
      @(negedge clk);
      check_eq("valid_latency", bus.o_valid,  DW'(1));
      check_eq("busy_done",     bus.o_busy,   '0);
      check_eq("ch_sel_done",   bus.o_ch_sel, '0);
   endtask

   // Pops and compares a result; stalls with i_ready low, optional chained start
   task automatic take_result(input int stall, input bit b2b);
      logic [DW-1:0] exp;
      int n;
      n = 0;
      while (bus.o_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("valid_seen", bus.o_valid, DW'(1));
      if (bus.o_valid !== 1'b1) return;
      if (exp_q.size() == 0) begin
         check_eq("sb_underflow", DW'(exp_q.size()), DW'(1));
         return;
      end
      exp = exp_q.pop_front();
      check_eq("data", bus.o_data, exp);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check_eq("stall_valid", bus.o_valid, DW'(1));
         check_eq("stall_data",  bus.o_data,  exp);
      end
      bus.i_ready = 1'b1;
      if (b2b) begin
         bus.i_start = 1'b1;
         return;
      end
      @(negedge clk);
      check_eq("valid_drop", bus.o_valid, '0);
      check_eq("idle_busy",  bus.o_busy,  '0);
      @(negedge clk);
      check_eq("idle_valid", bus.o_valid, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      bus.i_start = 1'($urandom);
      bus.i_ready = 1'($urandom);
      for (int c = 0; c < IN_CH; c++) set_chan(c, int'($urandom), int'($urandom));

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset_outputs("rst");
         bus.i_start = 1'($urandom);
      end
      bus.i_start = 1'b0;
      bus.i_ready = 1'b1;
      rst_n       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset_outputs("post_rst");
      end

      // Basic sum
      set_chan(0, 5, 100);
      set_chan(1, 7, -50);
      set_chan(2, -2, 1);
      exp_q.push_back(model_sum());
      check_eq("model_basic", exp_q[0], {32'sd51, 32'sd10});
      bus.i_start = 1'b1;
      do_accum(1'b0);
      take_result(0, 1'b0);

      // Backpressure for 5 cycles
      bus.i_ready = 1'b0;
      exp_q.push_back(model_sum());
      bus.i_start = 1'b1;
      do_accum(1'b0);
      take_result(5, 1'b0);

      // Back-to-back: first sum, then all-ones set started while accepting
      bus.i_ready = 1'b0;
      exp_q.push_back(model_sum());
      bus.i_start = 1'b1;
      do_accum(1'b0);
      for (int c = 0; c < IN_CH; c++) set_chan(c, 1, 1);
      exp_q.push_back(model_sum());
      take_result(1, 1'b1);
      do_accum(1'b0);
      take_result(0, 1'b0);

      // Extremes with a stray start during ACCUM
      for (int c = 0; c < IN_CH; c++) set_chan(c, -(1 << 29), -(1 << 29));
      exp_q.push_back(model_sum());
      bus.i_start = 1'b1;
      do_accum(1'b1);
      check_eq("ext_lane0", DW'(bus.o_data[31:0]),  DW'(32'hA000_0000));
      check_eq("ext_lane1", DW'(bus.o_data[63:32]), DW'(32'hA000_0000));
      take_result(0, 1'b0);
      check_eq("no_restart_busy", bus.o_busy, '0);

      // Mid-operation reset while o_ch_sel==1
      set_chan(0, 11, -3);
      set_chan(1, 22, -4);
      set_chan(2, 33, -5);
      exp_q.push_back(model_sum());
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      check_eq("mid_sel1", bus.o_ch_sel, DW'(1));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      void'(exp_q.pop_back());
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_reset_outputs("mid_hold");
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("mid_no_valid", bus.o_valid, '0);
      end

      // Fresh sum after the aborted one
      set_chan(0, -100, 3);
      set_chan(1, 40, 4);
      set_chan(2, 1, -8);
      exp_q.push_back(model_sum());
      bus.i_start = 1'b1;
      do_accum(1'b0);
      take_result(0, 1'b0);

      check_eq("sb_left", DW'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
